// File: rtl/ex_result_buffer_pkg.sv
// ex_result_buffer_pkg
//   Shared types and system-wide sizing for the execute result staging path.
//   result_packet_t : one functional-unit result as presented to cq.
//   EX_BUF_DEPTH    : entries per execute-lane result FIFO.
package ex_result_buffer_pkg;

    localparam int unsigned ROB_IDX_W    = 5;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned EX_BUF_DEPTH = 2;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_index;
        logic [XLEN-1:0]      result;
    } result_packet_t;

endpackage

// File: rtl/ex_lane_fifo.sv
// ex_lane_fifo
//   One execute lane's result FIFO.
//   Ports:
//     clock, reset (async, active-high), squash (sync flush)
//     push  : enqueue din this cycle (caller guarantees the FIFO is not full)
//     pop   : dequeue the head this cycle (caller guarantees it is not empty)
//     din   : result to enqueue
//     head  : oldest entry; head.valid is 1 exactly when count != 0
//     count : number of entries held
module ex_lane_fifo
    import ex_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = EX_BUF_DEPTH
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         push,
    input  logic                         pop,
    input  result_packet_t               din,
    output result_packet_t               head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    result_packet_t mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (squash) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: validity comes from count alone.
    always_ff @(posedge clock) begin
        if (push && !squash)
            mem[wr_ptr] <= din;
    end

    always_comb begin
        head       = mem[rd_ptr];
        head.valid = (count != '0);
    end

endmodule

// File: rtl/ex_result_buffer.sv
// ex_result_buffer
//   Per-lane result staging between the functional units and cq.
//   Each lane has an independent FIFO; cq back-pressures a lane via stall,
//   and the lane back-pressures its FU via fu_ready (registered count only).
//   Ports:
//     clock, reset (async, active-high), squash (sync flush of all lanes)
//     fu_result[i] / fu_ready[i] : FU offer / lane accept
//     execute[i]   / stall[i]    : result to cq / cq refuses this cycle
//     occupancy[i]               : entries held by lane i
//   Configuration macro: EX_RESULT_BYPASS_EN -- an empty lane forwards
//   fu_result straight to execute in the same cycle (0-cycle latency).
module ex_result_buffer
    import ex_result_buffer_pkg::*;
#(
    parameter int unsigned E_WIDTH = 7,
    parameter int unsigned DEPTH   = EX_BUF_DEPTH
)(
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     squash,
    input  result_packet_t [E_WIDTH-1:0]             fu_result,
    output logic [E_WIDTH-1:0]                       fu_ready,
    output result_packet_t [E_WIDTH-1:0]             execute,
    input  logic [E_WIDTH-1:0]                       stall,
    output logic [E_WIDTH-1:0][$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    for (genvar i = 0; i < E_WIDTH; i++) begin : g_lane
        result_packet_t head;
        logic [CW-1:0]  count;
        logic           push;
        logic           pop;

        // Full-lane-with-pop still refuses: no stall->fu_ready path.
        assign fu_ready[i] = !reset && (count < CW'(DEPTH));

`ifdef EX_RESULT_BYPASS_EN
        logic bypass;
        assign bypass     = (count == '0) && fu_result[i].valid && !reset;
        assign execute[i] = bypass ? fu_result[i] : head;
        // A bypassed result accepted by cq is consumed and never stored.
        assign push       = fu_result[i].valid && fu_ready[i] && !(bypass && !stall[i]);
`else
        assign execute[i] = head;
        assign push       = fu_result[i].valid && fu_ready[i];
`endif

        assign pop          = head.valid && !stall[i];
        assign occupancy[i] = count;

        ex_lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock  (clock),
            .reset  (reset),
            .squash (squash),
            .push   (push),
            .pop    (pop),
            .din    (fu_result[i]),
            .head   (head),
            .count  (count)
        );
    end

endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Per-lane result staging between the functional units and the completion queue (`cq`). Each of `E_WIDTH` execute lanes gets a small FIFO that absorbs results while `cq` back-pressures that lane through `stall`, and in turn back-pressures its functional unit through `fu_ready`. The block drives `cq`'s `execute` bus and consumes its `stall` vector, so results are never dropped or reordered within a lane.

## Interface
- `E_WIDTH`, default 7: number of execute lanes; must match `cq`'s `E_WIDTH`.
- `DEPTH`, default 2: entries per lane FIFO; must be at least 1.
- `clock`, input, 1 bit: single clock, rising edge.
- `reset`, input, 1 bit: asynchronous, active-high.
- `squash`, input, 1 bit: mispredict flush; empties every lane.
- `fu_result`, input, `result_packet_t [E_WIDTH-1:0]`: FU outputs; `.valid` marks an offered result.
- `fu_ready`, output, `[E_WIDTH-1:0]`: lane i accepts `fu_result[i]` this cycle.
- `execute`, output, `result_packet_t [E_WIDTH-1:0]`: results presented to `cq`.
- `stall`, input, `[E_WIDTH-1:0]`: from `cq`; lane i is not accepted this cycle.
- `occupancy`, output, `[E_WIDTH-1:0][$clog2(DEPTH+1)-1:0]`: entries held per lane, for debug and performance counters.

## Operation
- Lanes are fully independent; there is no cross-lane arbitration.
- FU push: lane i enqueues at posedge when `fu_result[i].valid && fu_ready[i]` and `squash` is low.
  - `fu_ready[i] = (count_i < DEPTH)`.
  - It depends only on registered count, so there is no `stall`→`fu_ready` combinational path.
- CQ pop: the lane head is dequeued at posedge when `execute[i].valid && !stall[i]`.
- `execute[i]` is the head entry when `count_i > 0`; otherwise `execute[i].valid = 0` and the other fields are don't-care.
- Push and pop in the same cycle: count is unchanged and the head and tail pointers both advance.
- Full lane with a pop in the same cycle: `fu_ready` is still 0, so there is no push that cycle and one cycle of throughput is lost. This is intentional.
- Pointers are `$clog2(DEPTH)` bits (1 bit minimum) and wrap modulo `DEPTH`; `DEPTH` need not be a power of 2, so wrap is explicit.
- `squash` (synchronous, at posedge):
  - All counts and pointers clear; pending pushes are dropped.
  - `execute` outputs are not gated in the squash cycle. `cq` handles its own squash.
- Reset (asynchronous):
  - Counts and pointers clear; `execute[*].valid = 0`; `occupancy = 0`.
  - `fu_ready` is forced to 0 while `reset` is high and reads all-ones in the first cycle after deassertion.
  - Reset mid-operation discards all held results.

## Timing
- Without bypass, latency from FU push to `execute[i].valid` is 1 cycle.
- Sustained throughput with `!stall` is 1 result per lane per cycle when `DEPTH >= 2`. `DEPTH = 1` gives 1 result per 2 cycles.
- `stall[i]` may toggle without regard to `execute[i].valid`; it is sampled only when valid.
- Once `execute[i].valid` rises, the packet holds stable until accepted or squashed.

## Configuration
- `EX_RESULT_BYPASS_EN` defined:
  - When lane i is empty and `fu_result[i].valid`, `execute[i] = fu_result[i]` combinationally, giving 0-cycle latency.
  - If `!stall[i]`, the result is consumed and not enqueued; otherwise it is enqueued as normal.
  - This adds a `fu_result`→`execute` combinational path.
- Undefined: `execute` always comes from registered storage, and latency is 1 cycle.

## Structure
- `result_packet_t` is reused from the shared package.
- Add `EX_BUF_DEPTH` (default 2) to the shared package as the system-wide `DEPTH` value.
- The natural sub-module is `ex_lane_fifo`: one lane's FIFO with push/pop/squash, count, and head output. It is instantiated `E_WIDTH` times in a generate loop. The top level holds only the bypass mux and the port fan-out.

## Test plan
- Reset, then push lane 0 with `rob_index=2`, `result=32'hdeadbeef`, `stall=0` → `execute[0].valid` next cycle with the same fields, one cycle later `occupancy[0]=0`, and `execute[1..6].valid=0`.
- Hold `stall=7'h7F` and push all lanes 3 cycles in a row (DEPTH=2) → after 2 pushes `fu_ready=0` and `occupancy=2`. Release `stall` → results emerge in push order, one per lane per cycle.
- Simultaneous push and pop on lane 3 at `occupancy=1` over 10 cycles with `rob_index` 0..9 → occupancy stays 1, the output sequence is exactly 0..9, and pointers wrap cleanly.
- Fill lanes 0–2, then pulse `squash` together with a push on lane 4 → the next cycle has all `execute.valid=0`, `occupancy=0`, and lane 4's result is absent.
- Assert `reset` asynchronously mid-cycle while lanes hold data → `execute.valid` drops immediately; after deassertion `fu_ready=7'h7F`.
- With `EX_RESULT_BYPASS_EN`: push to an empty lane with `stall=0` → `execute` valid in the same cycle and `occupancy` stays 0. Repeat with `stall=1` → `occupancy=1` next cycle.
